// File: rtl/intersection_phase_scheduler.sv
// Four-approach intersection scheduler: round-robin green with min/max timers,
// yellow and all-red clearance, and an exclusive pedestrian walk phase.
module intersection_phase_scheduler #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  parameter int WALK      = 6,
  parameter int TW        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sensor,
  input  logic       ped_req,
  output logic [7:0] lights,
  output logic       walk,
  output logic       ped_ack,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_WALK
  } state_t;

  localparam logic [TW-1:0] ALL_RED_LAST = TW'(ALL_RED - 1);
  localparam logic [TW-1:0] MIN_LAST     = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST     = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YELLOW_LAST  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] WALK_LAST    = TW'(WALK - 1);
  localparam logic [TW-1:0] TIMER_SAT    = '1;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [1:0]    phase_next;
  logic          ped_pending, ped_pending_next;

  logic [1:0]    rr_winner;
  logic [1:0]    rr_cand;
  logic          rr_found;
  logic          others;

  logic [7:0]    lights_next;
  logic          walk_next;
  logic          ped_ack_next;

  // Round-robin search starting just after the last granted approach, so the
  // current holder is considered last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rr_winner = phase;
    rr_cand   = phase;
    rr_found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = phase + 2'(k);
      if (!rr_found && sensor[rr_cand]) begin
        rr_winner = rr_cand;
        rr_found  = 1'b1;
      end
    end
  end

  always_comb begin
    others = ped_pending;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != phase && sensor[i]) begin
        others = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    unique case (state)
      S_ALL_RED: begin
        if (timer >= ALL_RED_LAST) begin
          if (ped_pending) begin
            state_next = S_WALK;
          end else if (|sensor) begin
            state_next = S_GREEN;
            phase_next = rr_winner;
          end
        end
      end
      S_GREEN: begin
        if (others && ((timer >= MIN_LAST && !sensor[phase]) || timer >= MAX_LAST)) begin
          state_next = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (timer >= YELLOW_LAST) begin
          state_next = S_ALL_RED;
        end
      end
      S_WALK: begin
        if (timer >= WALK_LAST) begin
          state_next = S_ALL_RED;
        end
      end
      default: state_next = S_ALL_RED;
    endcase
  end

  // The timer saturates so a long-resting green can max-out at once on demand.
  always_comb begin
    if (state_next != state) begin
      timer_next = '0;
    end else if (timer == TIMER_SAT) begin
      timer_next = timer;
    end else begin
      timer_next = timer + TW'(1);
    end
  end

  // Walk entry wins over a button press in the same cycle; presses during walk are ignored.
  always_comb begin
    ped_pending_next = ped_pending;
    if (state_next == S_WALK && state != S_WALK) begin
      ped_pending_next = 1'b0;
    end else if (ped_req && state != S_WALK) begin
      ped_pending_next = 1'b1;
    end
  end

  // Outputs are decoded from the next-state values so the registered lamps
  // line up with the state register rather than lagging it by a cycle.
  always_comb begin
    lights_next = '0;
    unique case (state_next)
      S_GREEN:  lights_next[{phase_next, 1'b0} +: 2] = LIGHT_GREEN;
      S_YELLOW: lights_next[{phase_next, 1'b0} +: 2] = LIGHT_YELLOW;
      default:  lights_next = {4{LIGHT_RED}};
    endcase
    walk_next    = (state_next == S_WALK);
    ped_ack_next = (state_next == S_WALK) && (timer_next == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_ALL_RED;
      timer       <= '0;
      phase       <= 2'd3;
      ped_pending <= 1'b0;
      lights      <= '0;
      walk        <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      state       <= state_next;
      timer       <= timer_next;
      phase       <= phase_next;
      ped_pending <= ped_pending_next;
      lights      <= lights_next;
      walk        <= walk_next;
      ped_ack     <= ped_ack_next;
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench for intersection_phase_scheduler: expected per-cycle lamp
// states are queued as each scenario is set up and popped as the DUT runs.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sensor;
  logic       ped_req;
  logic [7:0] lights;
  logic       walk;
  logic       ped_ack;
  logic [1:0] phase;

  typedef struct packed {
    logic [7:0] lights;
    logic       walk;
    logic       ack;
    logic [1:0] phase;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  intersection_phase_scheduler #(
    .MIN_GREEN(4),
    .MAX_GREEN(8),
    .YELLOW   (2),
    .ALL_RED  (1),
    .WALK     (3),
    .TW       (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sensor (sensor),
    .ped_req(ped_req),
    .lights (lights),
    .walk   (walk),
    .ped_ack(ped_ack),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] green_of(input int a);
    logic [7:0] v;
    v = 8'h02;
    return v << (2 * a);
  endfunction

  function automatic logic [7:0] yellow_of(input int a);
    logic [7:0] v;
    v = 8'h01;
    return v << (2 * a);
  endfunction

  task automatic push(input logic [7:0] l, input logic w, input logic a,
                      input logic [1:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(obs_t'{lights: l, walk: w, ack: a, phase: p});
    end
  endtask

  function automatic obs_t observe();
    return obs_t'{lights: lights, walk: walk, ack: ped_ack, phase: phase};
  endfunction

  // An empty queue yields lights=8'hFF, which the DUT can never legally drive.
  function automatic obs_t pop_exp();
    if (exp_q.size() == 0) return '1;
    return exp_q.pop_front();
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("lights=%b walk=%b ack=%b phase=%0d", o.lights, o.walk, o.ack, o.phase);
  endfunction

  task automatic do_reset(input logic [3:0] s, input logic p);
    rst     = 1'b1;
    sensor  = s;
    ped_req = p;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, expv;
    rst     = 1'b1;
    sensor  = 4'hF;
    ped_req = 1'b1;
    push(8'h00, 1'b0, 1'b0, 2'd3, 3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      got  = observe();
      expv = pop_exp();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL test_reset cycle %0d: actual %s expected %s", c, fmt(got), fmt(expv));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rest_green();
    obs_t got, expv;
    do_reset(4'b0100, 1'b0);
    push(8'h00, 1'b0, 1'b0, 2'd3, 1);
    push(green_of(2), 1'b0, 1'b0, 2'd2, 12);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      got  = observe();
      expv = pop_exp();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL test_rest_green cycle %0d: actual %s expected %s", c, fmt(got), fmt(expv));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_gap_out();
    obs_t got, expv;
    do_reset(4'b0100, 1'b0);
    push(8'h00, 1'b0, 1'b0, 2'd3, 1);
    push(green_of(2), 1'b0, 1'b0, 2'd2, 6);
    push(yellow_of(2), 1'b0, 1'b0, 2'd2, 2);
    push(8'h00, 1'b0, 1'b0, 2'd2, 1);
    push(green_of(0), 1'b0, 1'b0, 2'd0, 4);
    for (int c = 0; c < 14; c++) begin
      if (c == 6) sensor = 4'b0001;
      @(negedge clk);
      got  = observe();
      expv = pop_exp();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL test_gap_out cycle %0d: actual %s expected %s", c, fmt(got), fmt(expv));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_max_out();
    obs_t got, expv;
    do_reset(4'b0011, 1'b0);
    push(8'h00, 1'b0, 1'b0, 2'd3, 1);
    push(green_of(0), 1'b0, 1'b0, 2'd0, 8);
    push(yellow_of(0), 1'b0, 1'b0, 2'd0, 2);
    push(8'h00, 1'b0, 1'b0, 2'd0, 1);
    push(green_of(1), 1'b0, 1'b0, 2'd1, 8);
    push(yellow_of(1), 1'b0, 1'b0, 2'd1, 2);
    push(8'h00, 1'b0, 1'b0, 2'd1, 1);
    push(green_of(0), 1'b0, 1'b0, 2'd0, 2);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      got  = observe();
      expv = pop_exp();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL test_max_out cycle %0d: actual %s expected %s", c, fmt(got), fmt(expv));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_pedestrian();
    obs_t got, expv;
    do_reset(4'b0010, 1'b0);
    push(8'h00, 1'b0, 1'b0, 2'd3, 1);
    push(green_of(1), 1'b0, 1'b0, 2'd1, 4);
    push(yellow_of(1), 1'b0, 1'b0, 2'd1, 2);
    push(8'h00, 1'b0, 1'b0, 2'd1, 1);
    push(8'h00, 1'b1, 1'b1, 2'd1, 1);
    push(8'h00, 1'b1, 1'b0, 2'd1, 2);
    push(8'h00, 1'b0, 1'b0, 2'd1, 1);
    push(green_of(0), 1'b0, 1'b0, 2'd0, 3);
    for (int c = 0; c < 15; c++) begin
      case (c)
        1: sensor  = 4'b0000;
        2: ped_req = 1'b1;
        3: ped_req = 1'b0;
        9: sensor  = 4'b0001;
        default: ;
      endcase
      @(negedge clk);
      got  = observe();
      expv = pop_exp();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL test_pedestrian cycle %0d: actual %s expected %s", c, fmt(got), fmt(expv));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_rotation();
    obs_t got, expv;
    do_reset(4'hF, 1'b0);
    push(8'h00, 1'b0, 1'b0, 2'd3, 1);
    for (int k = 0; k < 4; k++) begin
      push(green_of(k), 1'b0, 1'b0, 2'(k), 8);
      push(yellow_of(k), 1'b0, 1'b0, 2'(k), 2);
      push(8'h00, 1'b0, 1'b0, 2'(k), 1);
    end
    push(green_of(0), 1'b0, 1'b0, 2'd0, 8);
    for (int c = 0; c < 53; c++) begin
      @(negedge clk);
      got  = observe();
      expv = pop_exp();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL test_rotation cycle %0d: actual %s expected %s", c, fmt(got), fmt(expv));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_walk();
    obs_t got, expv;
    do_reset(4'b0000, 1'b1);
    push(8'h00, 1'b0, 1'b0, 2'd3, 2);
    push(8'h00, 1'b1, 1'b1, 2'd3, 1);
    push(8'h00, 1'b0, 1'b0, 2'd3, 1);
    push(8'h00, 1'b0, 1'b0, 2'd3, 6);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) ped_req = 1'b0;
      @(negedge clk);
      got  = observe();
      expv = pop_exp();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL test_reset_mid_walk cycle %0d: actual %s expected %s", c, fmt(got), fmt(expv));
      end
      if (c < 2) begin
        @(posedge clk);
        #1;
      end
    end
    #2;
    rst = 1'b1;
    #1;
    got  = observe();
    expv = pop_exp();
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL test_reset_mid_walk async: actual %s expected %s", fmt(got), fmt(expv));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      got  = observe();
      expv = pop_exp();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL test_reset_mid_walk rest %0d: actual %s expected %s", c, fmt(got), fmt(expv));
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst     = 1'b1;
    sensor  = 4'b0000;
    ped_req = 1'b0;
    test_reset();
    test_rest_green();
    test_gap_out();
    test_max_out();
    test_pedestrian();
    test_rotation();
    test_reset_mid_walk();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
